// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes / InvSubBytes engine.
// A 128-bit state is accepted in IDLE, then LANES bytes are substituted per
// clock in RUN. The finished state is held in DONE until downstream takes it.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends combinationally on ready.
module sub_bytes_engine #(
    parameter int LANES  = 4,
    parameter bit INV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    // FIPS-197 forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_F = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // FIPS-197 inverse S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_I = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    work_q, work_d;
    logic            mode_q, mode_d;

    // One byte lookup; the inverse table is only reachable when INV_EN is set.
    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        int idx;
        idx = (255 - int'(b)) * 8;
        if (INV_EN && inv) return SBOX_I[idx +: 8];
        else               return SBOX_F[idx +: 8];
    endfunction

    // State register; reset aborts any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic: capture, substitute LANES bytes per cycle, hold result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    mode_d  = in_inv & INV_EN;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    int pos;
                    pos = 127 - 8 * (int'(cnt_q) * LANES + l);
                    work_d[pos -: 8] = sub_byte(work_q[pos -: 8], mode_q);
                end
                if (int'(cnt_q) == N - 1) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state only; partial results stay hidden.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_state = (state_q == DONE) ? work_q : '0;
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: six instances (LANES 1,2,4,8,16 with inverse
// support, plus LANES 4 forward-only), driven one at a time. Expected states
// come from an algorithmic GF(2^8) S-box model via an expected-result queue.
module tb_sub_bytes_engine;

    localparam int NK = 6;

    function automatic int lanes_of(input int k);
        return (k == 5) ? 4 : (1 << k);
    endfunction

    logic         clk;
    logic         rst;
    logic         in_valid    [NK];
    logic [127:0] in_state    [NK];
    logic         in_inv      [NK];
    logic         out_ready   [NK];
    logic         in_ready_w  [NK];
    logic         out_valid_w [NK];
    logic         busy_w      [NK];
    logic [127:0] out_state_w [NK];

    for (genvar g = 0; g < NK; g++) begin : g_dut
        sub_bytes_engine #(
            .LANES (lanes_of(g)),
            .INV_EN((g == 5) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready_w[g]),
            .in_state (in_state[g]),
            .in_inv   (in_inv[g]),
            .out_valid(out_valid_w[g]),
            .out_ready(out_ready[g]),
            .out_state(out_state_w[g]),
            .busy     (busy_w[g])
        );
    end

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   fwd_t [256];
    logic [7:0]   inv_t [256];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference model
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] y;
        y = 8'h00;
        if (x != 8'h00)
            for (int c = 1; c < 256; c++)
                if (gmul(x, 8'(c)) == 8'h01) y = 8'(c);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic inv);
        logic [127:0] r;
        logic [7:0] b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = st[127 - 8 * i -: 8];
            r[127 - 8 * i -: 8] = inv ? inv_t[b] : fwd_t[b];
        end
        return r;
    endfunction

    // driver: one complete transaction on instance k with a DONE stall
    task automatic txn(input int k, input logic [127:0] st, input logic inv,
                       input int stall, input bit pulse);
        int lat;
        logic [127:0] exp;
        exp_q.push_back(model(st, inv && (k != 5)));
        check("in_ready_before_accept", 128'(in_ready_w[k]), 128'd1);
        in_valid[k] = 1'b1;
        in_state[k] = st;
        in_inv[k]   = inv;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        in_state[k] = ~st;
        in_inv[k]   = ~inv;
        lat = 0;
        while (!out_valid_w[k] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency_k%0d", k), 128'(lat), 128'(16 / lanes_of(k)));
        exp = exp_q.pop_front();
        check($sformatf("result_k%0d", k), out_state_w[k], exp);
        for (int s = 0; s < stall; s++) begin
            if (pulse) begin
                in_valid[k] = 1'($urandom_range(0, 1));
                in_state[k] = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
            check("stall_out_state", out_state_w[k], exp);
            check("stall_out_valid", 128'(out_valid_w[k]), 128'd1);
            check("stall_in_ready", 128'(in_ready_w[k]), 128'd0);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        check("after_handshake_out_valid", 128'(out_valid_w[k]), 128'd0);
        check("after_handshake_in_ready", 128'(in_ready_w[k]), 128'd1);
    endtask

    initial begin
        for (int x = 0; x < 256; x++) fwd_t[x] = sbox_model(8'(x));
        for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
        for (int k = 0; k < NK; k++) begin
            in_valid[k] = 1'b0; in_state[k] = '0; in_inv[k] = 1'b0; out_ready[k] = 1'b0;
        end

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 128'(in_ready_w[2]), 128'd1);
        check("rst_out_valid", 128'(out_valid_w[2]), 128'd0);
        check("rst_out_state", out_state_w[2], 128'd0);
        check("rst_busy", 128'(busy_w[2]), 128'd0);

        // all-zero state forward
        txn(2, 128'h0, 1'b0, 0, 1'b0);

        // mixed pattern forward, then feed the result back inverted
        txn(2, {4{32'h0001_53ff}}, 1'b0, 0, 1'b0);
        txn(2, {4{32'h637c_ed16}}, 1'b1, 0, 1'b0);

        // back-pressure with ignored in_valid pulses in DONE
        txn(2, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 1'b0, 10, 1'b1);

        // out_ready pulse in IDLE does nothing
        out_ready[2] = 1'b1;
        @(posedge clk); #1;
        out_ready[2] = 1'b0;
        check("idle_ready_pulse_in_ready", 128'(in_ready_w[2]), 128'd1);
        check("idle_ready_pulse_out_valid", 128'(out_valid_w[2]), 128'd0);

        // reset two cycles into RUN
        in_valid[2] = 1'b1; in_state[2] = {4{32'hdead_beef}}; in_inv[2] = 1'b0;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("run_busy_before_rst", 128'(busy_w[2]), 128'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_rst_out_valid", 128'(out_valid_w[2]), 128'd0);
        check("midrun_rst_in_ready", 128'(in_ready_w[2]), 128'd1);
        check("midrun_rst_out_state", out_state_w[2], 128'd0);
        check("midrun_rst_busy", 128'(busy_w[2]), 128'd0);
        txn(2, {4{32'hdead_beef}}, 1'b0, 1, 1'b0);

        // random sweep across every LANES value
        for (int k = 0; k < 5; k++)
            for (int n = 0; n < 200; n++)
                txn(k, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'b1);

        // forward-only build ignores in_inv
        txn(5, 128'h0, 1'b1, 0, 1'b0);
        txn(5, {4{32'h0001_53ff}}, 1'b1, 2, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
